// File: rtl/spi_disp_pkg.sv
// Shared opcodes, FSM encoding and window defaults
// for the SPI display slave.
package spi_disp_pkg;

  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_RASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC = 8'h3C;

  localparam logic [15:0] COL_START_RST = 16'h0000;
  localparam logic [15:0] COL_END_RST   = 16'h00EF;
  localparam logic [15:0] ROW_START_RST = 16'h0000;
  localparam logic [15:0] ROW_END_RST   = 16'h013F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_RASET,
    ST_PIXEL,
    ST_SKIP
  } disp_st_e;

  function automatic disp_st_e cmd_state(
    input logic [7:0] cmd
  );
    disp_st_e st;
    unique case (1'b1)
      cmd == CMD_NOP:    st = ST_IDLE;
      cmd == CMD_CASET:  st = ST_CASET;
      cmd == CMD_RASET:  st = ST_RASET;
      cmd == CMD_RAMWR:  st = ST_PIXEL;
      cmd == CMD_RAMWRC: st = ST_PIXEL;
      default:           st = ST_SKIP;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: input synchronisers,
// SCLK edge detect, bit counter, byte strobe.
module spi_byte_rx #(
  parameter int P_SYNC_STG = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_spi_clk,
  input  logic       i_spi_cs,
  input  logic       i_spi_mosi,
  input  logic       i_spi_dc,
  output logic [7:0] o_byte,
  output logic       o_byte_vld,
  output logic       o_byte_dc,
  output logic       o_cs_rise
);

  logic [P_SYNC_STG-1:0] sclk_sync;
  logic [P_SYNC_STG-1:0] cs_sync;
  logic [P_SYNC_STG-1:0] mosi_sync;
  logic [P_SYNC_STG-1:0] dc_sync;
  logic                  sclk_d;
  logic                  cs_d;
  logic [2:0]            bit_cnt;
  logic [7:0]            shreg;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic dc_s;
  logic sclk_rise;
  logic cs_rise;
  logic [7:0] shreg_nxt;

  assign sclk_s    = sclk_sync[P_SYNC_STG-1];
  assign cs_s      = cs_sync[P_SYNC_STG-1];
  assign mosi_s    = mosi_sync[P_SYNC_STG-1];
  assign dc_s      = dc_sync[P_SYNC_STG-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign shreg_nxt = {shreg[6:0], mosi_s};

  // CS idles high, so its stages reset to 1
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      dc_sync   <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[P_SYNC_STG-2:0], i_spi_clk};
      cs_sync   <= {cs_sync[P_SYNC_STG-2:0], i_spi_cs};
      mosi_sync <= {mosi_sync[P_SYNC_STG-2:0], i_spi_mosi};
      dc_sync   <= {dc_sync[P_SYNC_STG-2:0], i_spi_dc};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      o_byte     <= 8'h00;
      o_byte_vld <= 1'b0;
      o_byte_dc  <= 1'b0;
      o_cs_rise  <= 1'b0;
    end else begin
      o_byte_vld <= 1'b0;
      o_cs_rise  <= cs_rise;
      if (cs_rise) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise && !cs_s) begin
        shreg   <= shreg_nxt;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          o_byte     <= shreg_nxt;
          o_byte_vld <= 1'b1;
          o_byte_dc  <= dc_s;
        end
      end
    end
  end

endmodule

// File: rtl/spi_disp_slave.sv
// SPI display slave: command FSM, window registers
// and pixel assembly on top of spi_byte_rx.
module spi_disp_slave
  import spi_disp_pkg::*;
#(
  parameter int P_PIX_BYTES = 2,
  parameter int P_SYNC_STG  = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_spi_clk,
  input  logic                     i_spi_cs,
  input  logic                     i_spi_mosi,
  input  logic                     i_spi_dc,
  output logic [8*P_PIX_BYTES-1:0] o_pixel_data,
  output logic                     o_pixel_en_pls,
  output logic                     o_vsync_pls,
  output logic [15:0]              o_col_start,
  output logic [15:0]              o_col_end,
  output logic [15:0]              o_row_start,
  output logic [15:0]              o_row_end,
  output logic                     o_win_upd_pls
);

  localparam int PW = 8 * P_PIX_BYTES;

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_dc;
  logic       cs_rise;

  spi_byte_rx #(
    .P_SYNC_STG (P_SYNC_STG)
  ) u_rx (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_spi_clk  (i_spi_clk),
    .i_spi_cs   (i_spi_cs),
    .i_spi_mosi (i_spi_mosi),
    .i_spi_dc   (i_spi_dc),
    .o_byte     (rx_byte),
    .o_byte_vld (rx_vld),
    .o_byte_dc  (rx_dc),
    .o_cs_rise  (cs_rise)
  );

  disp_st_e      state;
  disp_st_e      state_nxt;
  logic [1:0]    prm_cnt;
  logic [1:0]    prm_cnt_nxt;
  logic [1:0]    pix_cnt;
  logic [23:0]   prm_sr;
  logic [PW-9:0] pix_acc;
  logic [PW-1:0] pix_sh;

  logic cmd_byte;
  logic dat_byte;
  logic vsync_nxt;
  logic win_ld;
  logic pix_ld;

  assign cmd_byte = rx_vld & ~rx_dc & ~cs_rise;
  assign dat_byte = rx_vld & rx_dc & ~cs_rise;
  assign pix_sh   = {pix_acc, rx_byte};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      prm_cnt <= 2'd0;
    end else begin
      state   <= state_nxt;
      prm_cnt <= prm_cnt_nxt;
    end
  end

  // Commands override whatever state we are in
  always_comb begin
    state_nxt   = state;
    prm_cnt_nxt = prm_cnt;
    vsync_nxt   = 1'b0;
    win_ld      = 1'b0;
    pix_ld      = 1'b0;
    if (cmd_byte) begin
      state_nxt   = cmd_state(rx_byte);
      prm_cnt_nxt = 2'd0;
      vsync_nxt   = (rx_byte == CMD_RAMWR);
    end else if (dat_byte) begin
      unique case (state)
        ST_CASET, ST_RASET: begin
          if (prm_cnt == 2'd3) begin
            win_ld      = 1'b1;
            state_nxt   = ST_SKIP;
            prm_cnt_nxt = 2'd0;
          end else begin
            prm_cnt_nxt = prm_cnt + 2'd1;
          end
        end
        ST_PIXEL: begin
          pix_ld = (pix_cnt == 2'(P_PIX_BYTES - 1));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pix_cnt        <= 2'd0;
      pix_acc        <= '0;
      prm_sr         <= 24'h0;
      o_pixel_data   <= '0;
      o_pixel_en_pls <= 1'b0;
      o_vsync_pls    <= 1'b0;
      o_win_upd_pls  <= 1'b0;
      o_col_start    <= COL_START_RST;
      o_col_end      <= COL_END_RST;
      o_row_start    <= ROW_START_RST;
      o_row_end      <= ROW_END_RST;
    end else begin
      o_vsync_pls    <= vsync_nxt;
      o_win_upd_pls  <= win_ld;
      o_pixel_en_pls <= pix_ld;
      if (cs_rise || cmd_byte) begin
        pix_cnt <= 2'd0;
      end else if (dat_byte && state == ST_PIXEL) begin
        pix_acc <= pix_sh[PW-9:0];
        if (pix_ld) begin
          o_pixel_data <= pix_sh;
          pix_cnt      <= 2'd0;
        end else begin
          pix_cnt <= pix_cnt + 2'd1;
        end
      end
      if (dat_byte) begin
        prm_sr <= {prm_sr[15:0], rx_byte};
      end
      if (win_ld && state == ST_CASET) begin
        o_col_start <= prm_sr[23:8];
        o_col_end   <= {prm_sr[7:0], rx_byte};
      end
      if (win_ld && state == ST_RASET) begin
        o_row_start <= prm_sr[23:8];
        o_row_end   <= {prm_sr[7:0], rx_byte};
      end
    end
  end

endmodule

// File: tb/tb_spi_disp_slave.sv
// Randomised scoreboard bench for spi_disp_slave,
// two instances (2- and 3-byte pixels) on one bus.
module tb_spi_disp_slave;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  localparam int M_NONE = 0;
  localparam int M_COL  = 1;
  localparam int M_ROW  = 2;
  localparam int M_PIX  = 3;

  localparam int Q_PX2 = 0;
  localparam int Q_PX3 = 1;
  localparam int Q_VS2 = 2;
  localparam int Q_VS3 = 3;
  localparam int Q_WN2 = 4;
  localparam int Q_WN3 = 5;

  typedef struct {
    logic [63:0] v;
    int          c;
  } exp_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic sclk = 1'b0;
  logic cs   = 1'b1;
  logic mosi = 1'b0;
  logic dc   = 1'b0;

  logic [15:0] pd2;
  logic [23:0] pd3;
  logic pe2, vs2, wu2, pe3, vs3, wu3;
  logic [15:0] cs2, ce2, rs2, re2;
  logic [15:0] cs3, ce3, rs3, re3;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t q[6][$];

  int          mode;
  logic [7:0]  prm[$];
  logic [7:0]  b2[$];
  logic [7:0]  b3[$];
  logic [15:0] m_cs, m_ce, m_rs, m_re;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_disp_slave #(.P_PIX_BYTES(2), .P_SYNC_STG(SYNC)) dut2 (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_spi_clk      (sclk),
    .i_spi_cs       (cs),
    .i_spi_mosi     (mosi),
    .i_spi_dc       (dc),
    .o_pixel_data   (pd2),
    .o_pixel_en_pls (pe2),
    .o_vsync_pls    (vs2),
    .o_col_start    (cs2),
    .o_col_end      (ce2),
    .o_row_start    (rs2),
    .o_row_end      (re2),
    .o_win_upd_pls  (wu2)
  );

  spi_disp_slave #(.P_PIX_BYTES(3), .P_SYNC_STG(SYNC)) dut3 (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_spi_clk      (sclk),
    .i_spi_cs       (cs),
    .i_spi_mosi     (mosi),
    .i_spi_dc       (dc),
    .o_pixel_data   (pd3),
    .o_pixel_en_pls (pe3),
    .o_vsync_pls    (vs3),
    .o_col_start    (cs3),
    .o_col_end      (ce3),
    .o_row_start    (rs3),
    .o_row_end      (re3),
    .o_win_upd_pls  (wu3)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic mon(input int k, input string nm,
                     input logic stb,
                     input logic [63:0] act);
    exp_t e;
    if (stb) begin
      if (q[k].size() == 0) begin
        chk({nm, "_unexpected"}, 64'(stb), 64'd0);
      end else begin
        e = q[k].pop_front();
        chk({nm, "_val"}, act, e.v);
        chk({nm, "_lat"}, 64'(cyc), 64'(e.c));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(Q_PX2, "pix2", pe2, 64'(pd2));
      mon(Q_PX3, "pix3", pe3, 64'(pd3));
      mon(Q_VS2, "vsync2", vs2, 64'(vs2));
      mon(Q_VS3, "vsync3", vs3, 64'(vs3));
      mon(Q_WN2, "win2", wu2, {cs2, ce2, rs2, re2});
      mon(Q_WN3, "win3", wu3, {cs3, ce3, rs3, re3});
    end
  end

  task automatic model_reset();
    mode = M_NONE;
    prm.delete();
    b2.delete();
    b3.delete();
    m_cs = 16'h0000;
    m_ce = 16'h00EF;
    m_rs = 16'h0000;
    m_re = 16'h013F;
  endtask

  // Reference behaviour: what each byte means to a display
  task automatic model_byte(input logic d,
                            input logic [7:0] b,
                            input int t);
    exp_t e;
    e.c = t;
    if (!d) begin
      prm.delete();
      b2.delete();
      b3.delete();
      case (b)
        8'h2A: mode = M_COL;
        8'h2B: mode = M_ROW;
        8'h2C: begin
          mode = M_PIX;
          e.v  = 64'd1;
          q[Q_VS2].push_back(e);
          q[Q_VS3].push_back(e);
        end
        8'h3C:   mode = M_PIX;
        default: mode = M_NONE;
      endcase
    end else if (mode == M_COL || mode == M_ROW) begin
      prm.push_back(b);
      if (prm.size() == 4) begin
        if (mode == M_COL) begin
          m_cs = {prm[0], prm[1]};
          m_ce = {prm[2], prm[3]};
        end else begin
          m_rs = {prm[0], prm[1]};
          m_re = {prm[2], prm[3]};
        end
        e.v = {m_cs, m_ce, m_rs, m_re};
        q[Q_WN2].push_back(e);
        q[Q_WN3].push_back(e);
        prm.delete();
        mode = M_NONE;
      end
    end else if (mode == M_PIX) begin
      b2.push_back(b);
      b3.push_back(b);
      if (b2.size() == 2) begin
        e.v = 64'({b2[0], b2[1]});
        q[Q_PX2].push_back(e);
        b2.delete();
      end
      if (b3.size() == 3) begin
        e.v = 64'({b3[0], b3[1], b3[2]});
        q[Q_PX3].push_back(e);
        b3.delete();
      end
    end
  endtask

  // 4 clk per SCLK period, 2 low then 2 high
  task automatic send_byte(input logic d, input logic [7:0] b);
    int t;
    t = 0;
    for (int i = 7; i >= 0; i--) begin
      @(posedge clk); #1;
      sclk = 1'b0;
      mosi = b[i];
      dc   = d;
      @(posedge clk);
      @(posedge clk); #1;
      sclk = 1'b1;
      if (i == 0) t = cyc;
      @(posedge clk);
    end
    model_byte(d, b, t + LAT);
  endtask

  task automatic cs_low();
    @(posedge clk); #1;
    sclk = 1'b0;
    cs   = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic cs_pulse();
    @(posedge clk); #1;
    sclk = 1'b0;
    @(posedge clk); #1;
    cs = 1'b1;
    b2.delete();
    b3.delete();
    repeat (6) @(posedge clk);
    cs_low();
  endtask

  task automatic chk_regs(input string nm);
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    chk({nm, "_win2"}, {cs2, ce2, rs2, re2},
        {m_cs, m_ce, m_rs, m_re});
    chk({nm, "_win3"}, {cs3, ce3, rs3, re3},
        {m_cs, m_ce, m_rs, m_re});
  endtask

  task automatic chk_drain(input string nm);
    repeat (LAT + 4) @(posedge clk);
    for (int k = 0; k < 6; k++)
      chk($sformatf("%s_q%0d_left", nm, k),
          64'(q[k].size()), 64'd0);
  endtask

  task automatic chk_rst_vals(input string nm);
    @(negedge clk);
    chk({nm, "_pd2"}, 64'(pd2), 64'd0);
    chk({nm, "_pd3"}, 64'(pd3), 64'd0);
    chk({nm, "_stb"}, {pe2, vs2, wu2, pe3, vs3, wu3}, 64'd0);
    chk({nm, "_win2"}, {cs2, ce2, rs2, re2},
        {16'h0000, 16'h00EF, 16'h0000, 16'h013F});
    chk({nm, "_win3"}, {cs3, ce3, rs3, re3},
        {16'h0000, 16'h00EF, 16'h0000, 16'h013F});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmds [7];
    int r;
    cmds = '{8'h2A, 8'h2B, 8'h2C, 8'h3C, 8'h00, 8'h36, 8'h00};
    model_reset();
    repeat (3) @(posedge clk);
    chk_rst_vals("reset");
    #1 rst = 1'b0;
    cs_low();

    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hA5);
    send_byte(1'b1, 8'h5A);
    send_byte(1'b1, 8'h12);
    send_byte(1'b1, 8'h34);
    cs_pulse();

    send_byte(1'b0, 8'h3C);
    send_byte(1'b1, 8'h11);
    send_byte(1'b1, 8'h22);
    send_byte(1'b1, 8'h33);
    cs_pulse();

    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h10);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h7F);
    send_byte(1'b0, 8'h2B);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h20);
    send_byte(1'b0, 8'h2C);
    chk_regs("caset_raset");

    send_byte(1'b1, 8'hA5);
    cs_pulse();
    send_byte(1'b1, 8'h12);
    send_byte(1'b1, 8'h34);
    send_byte(1'b0, 8'h36);
    send_byte(1'b1, 8'h00);
    chk_drain("directed");

    for (int n = 0; n < 160; n++) begin
      r = $urandom_range(0, 11);
      if (r == 0) begin
        send_byte(1'b0, cmds[$urandom_range(0, 6)]);
      end else if (r == 1) begin
        send_byte(1'b0, 8'($urandom));
      end else if (r == 2) begin
        cs_pulse();
      end else begin
        send_byte(1'b1, 8'($urandom));
      end
    end
    chk_regs("random");
    chk_drain("random");

    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h01);
    send_byte(1'b1, 8'h02);
    send_byte(1'b1, 8'h03);
    send_byte(1'b1, 8'h04);
    send_byte(1'b0, 8'h2C);
    chk_drain("pre_rst");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      sclk = 1'b0;
      mosi = 1'b1;
      dc   = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      sclk = 1'b1;
      @(posedge clk);
    end
    #1 rst = 1'b1;
    sclk = 1'b0;
    cs   = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    chk_rst_vals("mid_rst");
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    cs_low();
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hBE);
    send_byte(1'b1, 8'hEF);
    send_byte(1'b1, 8'h42);
    send_byte(1'b0, 8'h2B);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h05);
    send_byte(1'b1, 8'h01);
    send_byte(1'b1, 8'h00);
    chk_regs("post_rst");
    chk_drain("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
